// File: rtl/single_multi_add_sub.sv
// Three-stage multi-operand binary32 adder/subtractor: align to the largest exponent,
// sum in one wide two's-complement accumulator, then normalise and pack with truncation.
module single_multi_add_sub #(
    parameter int N_TERMS    = 3,
    parameter int GUARD_BITS = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [32*N_TERMS-1:0]  x,
    input  logic [N_TERMS-1:0]     sub_mask,
    output logic                   out_valid,
    output logic [31:0]            d
);

    localparam int W  = 26 + GUARD_BITS + $clog2(N_TERMS);
    localparam int PW = $clog2(W);

    // ---------------- Stage 1: align ----------------
    logic [7:0]          max_exp_next;
    logic [N_TERMS-1:0]  nan_bits;
    logic signed [W-1:0] term_next [N_TERMS];

    // Zero-exponent terms can never raise the maximum, so flushing falls out naturally.
    always_comb begin
        max_exp_next = '0;
        for (int i = 0; i < N_TERMS; i++) begin
            if (x[32*i+23 +: 8] > max_exp_next) begin
                max_exp_next = x[32*i+23 +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_align
        logic [7:0]  exp_i;
        logic [22:0] mant_i;
        logic [7:0]  shift_i;
        logic [W-1:0] mag_i;

        assign exp_i   = x[32*gi+30 -: 8];
        assign mant_i  = x[32*gi+22 -: 23];
        assign shift_i = max_exp_next - exp_i;
        // Shifts of W or more naturally leave zero; bits falling off the bottom are truncated.
        assign mag_i   = (exp_i == 8'd0) ? '0
                       : ((W'({1'b1, mant_i}) << GUARD_BITS) >> shift_i);
        assign nan_bits[gi]  = (exp_i == 8'hFF);
        assign term_next[gi] = (x[32*gi+31] ^ sub_mask[gi]) ? -$signed(mag_i)
                                                           : $signed(mag_i);
    end

    logic signed [W-1:0] term_reg [N_TERMS];
    logic [7:0]          max_exp1_reg;
    logic                nan1_reg;
    logic                valid1_reg;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_TERMS; i++) begin
            term_reg[i] <= term_next[i];
        end
        max_exp1_reg <= max_exp_next;
        nan1_reg     <= |nan_bits;
    end

    // ---------------- Stage 2: sum ----------------
    logic signed [W-1:0] sum_next;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < N_TERMS; i++) begin
            sum_next = sum_next + term_reg[i];
        end
    end

    logic signed [W-1:0] sum_reg;
    logic [7:0]          max_exp2_reg;
    logic                nan2_reg;
    logic                valid2_reg;

    always_ff @(posedge clk) begin
        sum_reg      <= sum_next;
        max_exp2_reg <= max_exp1_reg;
        nan2_reg     <= nan1_reg;
    end

    // ---------------- Stage 3: normalise / pack ----------------
    logic [W-1:0]  abs_val;
    logic [PW-1:0] lead;
    logic [11:0]   e_val;
    logic [W-1:0]  norm;
    logic [31:0]   result;

    always_comb begin
        abs_val = sum_reg[W-1] ? -sum_reg : sum_reg;
        lead    = '0;
        for (int i = 0; i < W; i++) begin
            if (abs_val[i]) begin
                lead = PW'(i);
            end
        end
        // 12-bit wrap-around arithmetic; bit 11 doubles as the sign of the exponent.
        e_val  = 12'(max_exp2_reg) + 12'(lead) - 12'(23 + GUARD_BITS);
        norm   = abs_val << (PW'(W - 1) - lead);
        result = {sum_reg[W-1], e_val[7:0], 23'(norm >> (W - 24))};
        if (nan2_reg) begin
            result = 32'h7FC0_0000;
        end else if (abs_val == '0) begin
            result = 32'h0;
        end else if (e_val[11] || (e_val == 12'd0)) begin
            result = 32'h0;
        end else if (e_val >= 12'd255) begin
            result = {sum_reg[W-1], 8'hFF, 23'h0};
        end
    end

    // Valid chain and output register; d is held at zero whenever out_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid1_reg <= 1'b0;
            valid2_reg <= 1'b0;
            out_valid  <= 1'b0;
            d          <= 32'h0;
        end else begin
            valid1_reg <= in_valid;
            valid2_reg <= valid1_reg;
            out_valid  <= valid2_reg;
            d          <= valid2_reg ? result : 32'h0;
        end
    end

endmodule

// File: doc/single_multi_add_sub.md
# single_multi_add_sub

Pipelined, parametrised single-precision (IEEE-754 binary32) multi-operand adder/subtractor. It computes d = ±x0 ± x1 ± … ± x(N_TERMS-1) in one shared-exponent fixed-point sum, with a per-term subtract mask. It sits in the Precision/Single datapath wherever three or more float terms are combined at once, such as dot-product tails or residual updates. It accepts one operand set per clock and returns a result a fixed 3 cycles later.

## Interface
- N_TERMS, 3: number of float operands, 2..16.
- GUARD_BITS, 15: fraction bits kept below each mantissa LSB after alignment.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid this cycle.
- x  input  32*N_TERMS  operands; term i = x[32*i+31:32*i].
- sub_mask  input  N_TERMS  bit i = 1: term i is subtracted (sign inverted).
- out_valid  output  1  d valid; reset value 0.
- d  output  32  result; reset value 0; forced to 0 whenever out_valid = 0.

## Operation
- Internal width: W = 26 + GUARD_BITS + clog2(N_TERMS).
- Denormals are flushed:
  - Any term with exp = 0 is treated as exact zero and does not count toward max_exp.
  - If all terms are zero, max_exp = 0.
- Special inputs: if any term has exp = 255 (Inf or NaN), the result is quiet NaN 0x7FC00000 regardless of the other terms.
- Stage 1 (align):
  - Effective sign s_i = x_i[31] XOR sub_mask[i].
  - max_exp = largest exponent among non-zero terms.
  - Magnitude {1, mant} << GUARD_BITS, right-shifted by (max_exp − exp_i); shift ≥ W gives 0. Bits shifted out are truncated.
  - Negated to two's complement when s_i = 1, sign-extended to W.
  - Registered: terms, max_exp, nan flag, valid.
- Stage 2 (sum): W-bit two's-complement sum of all terms; registered with max_exp, nan flag, valid.
- Stage 3 (normalise/pack):
  - sign = sum[W-1]; abs = |sum|.
  - p = index of the leading one in abs.
  - e = max_exp + p − (23 + GUARD_BITS), computed signed and at least 10 bits wide.
  - abs = 0 → d = 0x00000000 (+0, even if the inputs were −x + x).
  - e ≤ 0 → d = 0x00000000 (underflow flushed to zero).
  - e ≥ 255 → d = {sign, 8'hFF, 23'h0}, i.e. signed infinity.
  - Otherwise d = {sign, e[7:0], the 23 bits directly below the leading one}. Rounding is truncation toward zero: the bits are left-shifted with zero fill when p < 23, and lower bits are dropped when p > 23.
  - nan flag overrides all of the above.

## Timing
- Latency: exactly 3 clk from in_valid sampled high to out_valid high with the matching d.
- Throughput: one operand set per cycle, no stalls, no backpressure. Sets issued on consecutive cycles appear in order on consecutive cycles.
- A cycle with in_valid = 0 produces a bubble: out_valid = 0 and d = 0 three cycles later.
- Data registers may hold stale values, but d is gated by out_valid so it is never visible.
- Reset:
  - Clears all three valid stages, out_valid and the d register on the next edge.
  - Operand sets in flight when reset is asserted are discarded and never produce out_valid.
  - A set with in_valid high in the cycle reset is asserted is also discarded.
  - The first set accepted after reset deasserts appears 3 cycles later.
- There are no combinational paths from inputs to outputs.

## Test plan
- N_TERMS=3, x = {0x3F800000, 0x40000000, 0x3F000000}, sub_mask = 3'b100 → d = 0x40200000 (2.5) at cycle +3; out_valid is a single-cycle pulse.
- Cancellation and sign: {0x3F800000, 0x3F800000, 0}, mask 3'b010 → 0x00000000. {0x3F800000, 0x40400000, 0}, mask 3'b010 → 0xC0000000 (−2.0).
- Saturation and specials:
  - {0x7F7FFFFF, 0x7F7FFFFF, 0}, mask 0 → 0x7F800000.
  - Any term 0x7F800000 or 0x7FC00001 → 0x7FC00000.
  - Any denormal term (e.g. 0x00000001) contributes 0.
- Alignment loss: {0x4B800000 (2^24), 0x3F800000, 0}, mask 0 → 0x4B800000. The 1.0 term is truncated because it falls below the 23-bit result fraction.
- Streaming: 20 random sets on consecutive cycles with a bubble at cycle 7 → results match a reference model bit-exactly, in order, with a bubble at cycle 10 and d = 0 there.
- Reset mid-flight: issue 3 sets, assert reset for 1 cycle on the third → none of the 3 ever produce out_valid. The next set after reset emerges 3 cycles later with the correct value.
- Parameter sweep: N_TERMS = 2 and 16, GUARD_BITS = 0 and 24 → the 2.5 case and the cancellation case repeated with zero-padded terms give the same outputs.
